axi_wr_mux: RTL

Write-path channel mux between the two masters and the single slave, directly downstream of the two-master arbiter. Consumes the arbiter's `mas_sel` grant, latches the owner, and routes that master's AW, W and B channels to and from the slave. Counts write beats against the captured burst length. Pulses `endtrans` back to the arbiter once the write response handshake completes, which releases the grant.

---
 rtl/axi_wr_mux_if.sv | 30 +++
 rtl/axi_wr_mux.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/axi_wr_mux_if.sv
// One AXI write-path port (AW, W, B channels).
// A master drives AW/W and accepts B; a slave does the opposite.
interface axi_wr_mux_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_wr_mux.sv
// Write-path mux from two masters to one slave. Latches the arbiter grant,
// routes the owner's AW/W/B channels and pulses endtrans when the burst is done.
module axi_wr_mux #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          mas_sel_i,
    output logic                endtrans_o,
    output logic                wlast_err_o,
    axi_wr_mux_if.slave         m1_if,
    axi_wr_mux_if.slave         m2_if,
    axi_wr_mux_if.master        s_if
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               endTrans_q, endTrans_d;
    logic               wlastErr_q, wlastErr_d;

    logic                ownM1, ownM2;
    logic [ADDR_W-1:0]   selAwaddr;
    logic [LEN_W-1:0]    selAwlen;
    logic                selAwvalid;
    logic [DATA_W-1:0]   selWdata;
    logic [DATA_W/8-1:0] selWstrb;
    logic                selWlast;
    logic                selWvalid;
    logic                selBready;
    logic                lastBeat;

    assign ownM1 = (owner_q == 2'b01);
    assign ownM2 = (owner_q == 2'b10);

    // Owner-side view of the master inputs; only meaningful once owner_q is set.
    assign selAwaddr  = ownM2 ? m2_if.awaddr  : m1_if.awaddr;
    assign selAwlen   = ownM2 ? m2_if.awlen   : m1_if.awlen;
    assign selAwvalid = ownM2 ? m2_if.awvalid : (ownM1 & m1_if.awvalid);
    assign selWdata   = ownM2 ? m2_if.wdata   : m1_if.wdata;
    assign selWstrb   = ownM2 ? m2_if.wstrb   : m1_if.wstrb;
    assign selWlast   = ownM2 ? m2_if.wlast   : m1_if.wlast;
    assign selWvalid  = ownM2 ? m2_if.wvalid  : (ownM1 & m1_if.wvalid);
    assign selBready  = ownM2 ? m2_if.bready  : (ownM1 & m1_if.bready);
    assign lastBeat   = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= 2'b00;
            cnt_q      <= '0;
            endTrans_q <= 1'b0;
            wlastErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            endTrans_q <= endTrans_d;
            wlastErr_q <= wlastErr_d;
        end
    end

    // Channel routing is purely combinational; every output idles at 0 unless
    // the current state routes it, so the non-owner only ever sees zeros.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        endTrans_d = 1'b0;
        wlastErr_d = 1'b0;

        s_if.awaddr   = '0;
        s_if.awlen    = '0;
        s_if.awvalid  = 1'b0;
        s_if.wdata    = '0;
        s_if.wstrb    = '0;
        s_if.wlast    = 1'b0;
        s_if.wvalid   = 1'b0;
        s_if.bready   = 1'b0;
        m1_if.awready = 1'b0;
        m1_if.wready  = 1'b0;
        m1_if.bresp   = 2'b00;
        m1_if.bvalid  = 1'b0;
        m2_if.awready = 1'b0;
        m2_if.wready  = 1'b0;
        m2_if.bresp   = 2'b00;
        m2_if.bvalid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mas_sel_i == 2'b01 || mas_sel_i == 2'b10) begin
                    owner_d = mas_sel_i;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_if.awaddr   = selAwaddr;
                s_if.awlen    = selAwlen;
                s_if.awvalid  = selAwvalid;
                m1_if.awready = ownM1 & s_if.awready;
                m2_if.awready = ownM2 & s_if.awready;
                if (selAwvalid && s_if.awready) begin
                    cnt_d   = selAwlen;
                    state_d = DATA;
                end
            end
            DATA: begin
                s_if.wdata   = selWdata;
                s_if.wstrb   = selWstrb;
                s_if.wlast   = lastBeat;
                s_if.wvalid  = selWvalid;
                m1_if.wready = ownM1 & s_if.wready;
                m2_if.wready = ownM2 & s_if.wready;
                if (selWvalid && s_if.wready) begin
                    if (lastBeat) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                    wlastErr_d = (selWlast != lastBeat);
                end
            end
            RESP: begin
                s_if.bready  = selBready;
                m1_if.bresp  = ownM1 ? s_if.bresp : 2'b00;
                m1_if.bvalid = ownM1 & s_if.bvalid;
                m2_if.bresp  = ownM2 ? s_if.bresp : 2'b00;
                m2_if.bvalid = ownM2 & s_if.bvalid;
                if (s_if.bvalid && selBready) begin
                    endTrans_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                owner_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                owner_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    assign endtrans_o  = endTrans_q;
    assign wlast_err_o = wlastErr_q;

endmodule
